// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand interface between the request issuer and `chip`.
//   operation_t      : 2-bit opcode understood by `chip` (nop/add/sub).
//   CHIP_LAT_DEFAULT : default `chip` latency, in_valid sampled -> out_valid asserted.
package alu_pkg;

    typedef enum logic [1:0] {
        OpNop = 2'h0,
        OpAdd = 2'h1,
        OpSub = 2'h2
    } operation_t;

    localparam int unsigned CHIP_LAT_DEFAULT = 2;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous FIFO that holds responses until they are returned in order.
// Storage is register-based, so a pushed entry becomes visible on the cycle after the push
// (no fall-through). Push and pop may happen together at any fill level, including
// full-with-pop. Pointers wrap modulo DEPTH, so DEPTH must be a power of 2.
//   clk_i / rst_i : clock, synchronous active-high reset (clears contents and pointers)
//   push_i/wdata_i: write one entry
//   pop_i         : drop the head entry; ignored while empty
//   rdata_o       : head entry
//   empty_o       : no entries stored
//   count_o       : number of entries stored, 0..DEPTH
module rsp_fifo #(
    parameter int unsigned DW    = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [DW-1:0]                wdata_i,
    input  logic                         pop_i,
    output logic [DW-1:0]                rdata_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DW-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot this cycle, so a push into a full FIFO is fine alongside it.
    assign do_push = push_i & (~full | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_req_issuer.sv
// Initiator side of the `chip` ALU operand interface.
// Requests accepted on req_* are registered onto chip_op/a/b/in_valid the following cycle.
// `chip` has a fixed latency and no backpressure, so every accepted request reserves one
// response-FIFO slot (credit) until the response is consumed: req_ready only rises when
// outstanding + fifo_count < DEPTH, computed purely from registered state.
// The opcode of each issued op travels down a CHIP_LAT-deep tag pipeline so it lines up
// with chip_out_valid and is returned alongside the result on rsp_op.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   req_valid/ready, req_op/a/b       : request handshake and fields
//   chip_op/a/b, chip_in_valid        : drive `chip` inputs
//   chip_out, chip_out_valid          : `chip` result
//   rsp_valid/ready, rsp_data, rsp_op : in-order response handshake
//   busy                              : ops in flight or responses pending
//   proto_err                         : sticky, chip_out_valid seen with nothing outstanding
//   mismatch                          : sticky, only with ALU_REQ_ISSUER_CHECK_EN defined;
//                                       local reference result disagreed with chip_out
module alu_req_issuer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CHIP_LAT = CHIP_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [1:0]       chip_op,
    output logic [WIDTH-1:0] chip_a,
    output logic [WIDTH-1:0] chip_b,
    output logic             chip_in_valid,
    input  logic [WIDTH-1:0] chip_out,
    input  logic             chip_out_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_op,
    output logic             busy,
    output logic             proto_err
`ifdef ALU_REQ_ISSUER_CHECK_EN
    ,
    output logic             mismatch
`endif
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [1:0]       chip_op_q;
    logic [WIDTH-1:0] chip_a_q;
    logic [WIDTH-1:0] chip_b_q;
    logic             chip_in_valid_q;
    logic [CntW-1:0]  outstanding_q;
    logic [CntW-1:0]  outstanding_d;
    logic             proto_err_q;
    logic [1:0]       tag_q [CHIP_LAT];
    logic [1:0]       tag_op;

    logic [CntW-1:0]  fifo_count;
    logic             fifo_empty;
    logic [WIDTH+1:0] fifo_rdata;
    logic [CntW:0]    credits_used;
    logic             accept;
    logic             capture;

    // One bit wider than the counters so outstanding + fifo_count cannot wrap.
    assign credits_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign req_ready    = (credits_used < (CntW + 1)'(DEPTH));
    assign accept       = req_valid & req_ready;
    // Results with no op outstanding are stale (e.g. launched before a reset) and dropped.
    assign capture      = chip_out_valid & (outstanding_q != '0);
    assign tag_op       = tag_q[CHIP_LAT-1];

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({accept, capture})
            2'b10:   outstanding_d = outstanding_q + CntW'(1);
            2'b01:   outstanding_d = outstanding_q - CntW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chip_op_q       <= OpNop;
            chip_a_q        <= '0;
            chip_b_q        <= '0;
            chip_in_valid_q <= 1'b0;
            outstanding_q   <= '0;
            proto_err_q     <= 1'b0;
        end else begin
            chip_in_valid_q <= accept;
            // Operands hold between issues; only chip_in_valid marks a new op.
            if (accept) begin
                chip_op_q <= req_op;
                chip_a_q  <= req_a;
                chip_b_q  <= req_b;
            end
            outstanding_q <= outstanding_d;
            if (chip_out_valid && (outstanding_q == '0)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // Shifts every cycle; the stage-(CHIP_LAT-1) entry is only consumed on chip_out_valid,
    // which is exactly when it holds the op that produced the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(CHIP_LAT); i++) begin
                tag_q[i] <= OpNop;
            end
        end else begin
            tag_q[0] <= chip_op_q;
            for (int i = 1; i < int'(CHIP_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    rsp_fifo #(
        .DW    (WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (capture),
        .wdata_i ({tag_op, chip_out}),
        .pop_i   (rsp_valid & rsp_ready),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef ALU_REQ_ISSUER_CHECK_EN
    logic [WIDTH-1:0] a_pipe_q [CHIP_LAT];
    logic [WIDTH-1:0] b_pipe_q [CHIP_LAT];
    logic [WIDTH-1:0] expect_res;
    logic             mismatch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(CHIP_LAT); i++) begin
                a_pipe_q[i] <= '0;
                b_pipe_q[i] <= '0;
            end
        end else begin
            a_pipe_q[0] <= chip_a_q;
            b_pipe_q[0] <= chip_b_q;
            for (int i = 1; i < int'(CHIP_LAT); i++) begin
                a_pipe_q[i] <= a_pipe_q[i-1];
                b_pipe_q[i] <= b_pipe_q[i-1];
            end
        end
    end

    always_comb begin
        expect_res = '0;
        case (tag_op)
            OpAdd:   expect_res = a_pipe_q[CHIP_LAT-1] + b_pipe_q[CHIP_LAT-1];
            OpSub:   expect_res = a_pipe_q[CHIP_LAT-1] - b_pipe_q[CHIP_LAT-1];
            default: expect_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else if (capture && (chip_out != expect_res)) begin
            mismatch_q <= 1'b1;
        end
    end

    assign mismatch = mismatch_q;
`endif

    assign chip_op       = chip_op_q;
    assign chip_a        = chip_a_q;
    assign chip_b        = chip_b_q;
    assign chip_in_valid = chip_in_valid_q;
    assign rsp_valid     = ~fifo_empty;
    assign rsp_data      = fifo_rdata[WIDTH-1:0];
    assign rsp_op        = fifo_rdata[WIDTH+1:WIDTH];
    assign busy          = (outstanding_q != '0) | ~fifo_empty;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_alu_req_issuer.sv
// Directed bench for alu_req_issuer with a behavioural two-stage `chip` model.
// The chip model is not reset, so ops launched before a reset still emerge afterwards.
// Optional checker section is compiled when ALU_REQ_ISSUER_CHECK_EN is defined.
module tb_alu_req_issuer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [1:0] chip_op;
    logic [7:0] chip_a;
    logic [7:0] chip_b;
    logic       chip_in_valid;
    logic [7:0] chip_out;
    logic       chip_out_valid;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_op;
    logic       busy;
    logic       proto_err;
`ifdef ALU_REQ_ISSUER_CHECK_EN
    logic       mismatch;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_req_issuer #(
        .WIDTH    (8),
        .DEPTH    (4),
        .CHIP_LAT (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_a          (req_a),
        .req_b          (req_b),
        .chip_op        (chip_op),
        .chip_a         (chip_a),
        .chip_b         (chip_b),
        .chip_in_valid  (chip_in_valid),
        .chip_out       (chip_out),
        .chip_out_valid (chip_out_valid),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_op         (rsp_op),
        .busy           (busy),
        .proto_err      (proto_err)
`ifdef ALU_REQ_ISSUER_CHECK_EN
        ,
        .mismatch       (mismatch)
`endif
    );

    // Behavioural chip: samples in_valid at a rising edge, out_valid two cycles later.
    logic       corrupt = 1'b0;
    logic       c_v1 = 1'b0;
    logic       c_v2 = 1'b0;
    logic [7:0] c_r1 = 8'h00;
    logic [7:0] c_r2 = 8'h00;

    function automatic logic [7:0] chip_calc(input logic [1:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        case (op)
            2'h1:    return a + b;
            2'h2:    return a - b;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        c_v1 <= chip_in_valid;
        c_r1 <= chip_calc(chip_op, chip_a, chip_b) + {7'd0, corrupt};
        c_v2 <= c_v1;
        c_r2 <= c_r1;
    end

    assign chip_out       = c_r2;
    assign chip_out_valid = c_v2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp);
        rsp_ready = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        wait_rsp(tag);
        chk({tag, " data"}, 32'(rsp_data), 32'(exp));
        chk({tag, " op"}, 32'(rsp_op), 32'(op));
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " chip_in_valid"}, 32'(chip_in_valid), 32'd0);
        chk({tag, " chip_op"}, 32'(chip_op), 32'd0);
        chk({tag, " chip_a"}, 32'(chip_a), 32'd0);
        chk({tag, " chip_b"}, 32'(chip_b), 32'd0);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, " rsp_op"}, 32'(rsp_op), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " proto_err"}, 32'(proto_err), 32'd0);
    endtask

    initial begin
        int accepts;
        int got;
        int seen;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'h0;
        req_a     = 8'h00;
        req_b     = 8'h00;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
`ifdef ALU_REQ_ISSUER_CHECK_EN
        chk("reset mismatch", 32'(mismatch), 32'd0);
`endif
        rst = 1'b0;

        // Latency: accept in cycle 0, response visible in cycle 4.
        rsp_ready = 1'b1;
        req_op    = OpAdd;
        req_a     = 8'd5;
        req_b     = 8'd3;
        req_valid = 1'b1;
        chk("lat req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("lat c1 chip_in_valid", 32'(chip_in_valid), 32'd1);
        chk("lat c1 chip_op", 32'(chip_op), 32'd1);
        chk("lat c1 chip_a", 32'(chip_a), 32'd5);
        chk("lat c1 chip_b", 32'(chip_b), 32'd3);
        chk("lat c1 rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("lat c2 chip_in_valid", 32'(chip_in_valid), 32'd0);
        chk("lat c2 chip_a hold", 32'(chip_a), 32'd5);
        chk("lat c2 rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("lat c3 rsp_valid", 32'(rsp_valid), 32'd0);
        chk("lat c3 busy", 32'(busy), 32'd1);
        tick();
        chk("lat c4 rsp_valid", 32'(rsp_valid), 32'd1);
        chk("lat c4 rsp_data", 32'(rsp_data), 32'd8);
        chk("lat c4 rsp_op", 32'(rsp_op), 32'd1);
        tick();
        chk("lat c5 rsp_valid", 32'(rsp_valid), 32'd0);
        chk("lat c5 busy", 32'(busy), 32'd0);

        run_op("sub 3-5", OpSub, 8'h03, 8'h05, 8'hFE);
        run_op("nop 7,9", OpNop, 8'h07, 8'h09, 8'h00);
        run_op("add wrap", OpAdd, 8'hFF, 8'h01, 8'h00);
        run_op("sub wrap", OpSub, 8'h00, 8'h01, 8'hFF);

        // Backpressure: credits run out after DEPTH accepts.
        rsp_ready = 1'b0;
        req_op    = OpAdd;
        req_b     = 8'h01;
        req_valid = 1'b1;
        accepts   = 0;
        for (int c = 0; c < 12; c++) begin
            req_a = 8'h20 + 8'(accepts);
            if (req_ready) accepts++;
            tick();
        end
        req_valid = 1'b0;
        chk("bp accepts", 32'(accepts), 32'd4);
        chk("bp req_ready", 32'(req_ready), 32'd0);
        chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid) begin
                chk("bp order", 32'(rsp_data), 32'(32'h21 + got));
                got++;
            end
            tick();
        end
        chk("bp count", 32'(got), 32'd4);
        chk("bp busy", 32'(busy), 32'd0);

        // Issue resumes back-to-back once credits return.
        req_op    = OpSub;
        req_b     = 8'h10;
        req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            req_a = 8'h50 + 8'(c);
            chk("resume req_ready", 32'(req_ready), 32'd1);
            tick();
        end
        req_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid) begin
                chk("resume order", 32'(rsp_data), 32'(32'h40 + got));
                chk("resume op", 32'(rsp_op), 32'd2);
                got++;
            end
            tick();
        end
        chk("resume count", 32'(got), 32'd4);
`ifdef ALU_REQ_ISSUER_CHECK_EN
        chk("clean mismatch", 32'(mismatch), 32'd0);
`endif

        // Reset mid-flight: both ops are discarded, their late results flag proto_err.
        req_op    = OpAdd;
        req_a     = 8'h01;
        req_b     = 8'h01;
        req_valid = 1'b1;
        chk("rst ready0", 32'(req_ready), 32'd1);
        tick();
        req_a = 8'h02;
        chk("rst ready1", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("midrst");
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid) seen++;
            tick();
        end
        chk("midrst no rsp", 32'(seen), 32'd0);
        chk("midrst proto_err", 32'(proto_err), 32'd1);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst req_ready", 32'(req_ready), 32'd1);

`ifdef ALU_REQ_ISSUER_CHECK_EN
        chk("mm after rst", 32'(mismatch), 32'd0);
        corrupt = 1'b1;
        run_op("mm add", OpAdd, 8'h02, 8'h02, 8'h05);
        corrupt = 1'b0;
        chk("mm set", 32'(mismatch), 32'd1);
        tick();
        tick();
        tick();
        chk("mm sticky", 32'(mismatch), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
